// File: rtl/branch_cond_unit.sv
// Branch resolution stage for Power ISA b / bc / bclr / bcctr.
// Owns the architected CTR and LR, evaluates branch conditions against the
// condition register, and hands the next instruction address to fetch
// through a single registered valid/ready output slot.
module branch_cond_unit #(
   parameter int unsigned        XLEN    = 64,
   parameter logic [0:XLEN-1]    RST_CTR = '0,
   parameter logic [0:XLEN-1]    RST_LR  = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   // instruction side
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [0:31]        i_instr,
   input  logic [0:XLEN-1]    i_cia,
   input  logic               i_b,
   input  logic               i_bc,
   input  logic               i_bclr,
   input  logic               i_bcctr,
   input  logic [0:31]        i_cr,
   // mtctr / mtlr write port
   input  logic               i_spr_we,
   input  logic               i_spr_sel,
   input  logic [0:XLEN-1]    i_spr_wdata,
   // result side
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_taken,
   output logic [0:XLEN-1]    o_nia,
   // architected registers
   output logic [0:XLEN-1]    o_ctr,
   output logic [0:XLEN-1]    o_lr
);

   // ------------------------------------------------------------------
   // Instruction fields (Power bit numbering, bit 0 = MSB)
   // ------------------------------------------------------------------
   logic [0:4]       bo;
   logic [0:4]       bi;
   logic [0:13]      bd;
   logic [0:23]      li;
   logic             aa;
   logic             lk;

   assign bo = i_instr[6:10];
   assign bi = i_instr[11:15];
   assign bd = i_instr[16:29];
   assign li = i_instr[6:29];
   assign aa = i_instr[30];
   assign lk = i_instr[31];

   // Primary opcode is already decoded upstream into the one-hot strobes.
   logic unused_opcode;
   assign unused_opcode = ^i_instr[0:5];

   // ------------------------------------------------------------------
   // Architected state
   // ------------------------------------------------------------------
   logic [0:XLEN-1]  ctr_q;
   logic [0:XLEN-1]  lr_q;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic             accept;
   logic             any_branch;

   assign o_ready    = !o_valid || i_ready;
   assign accept     = i_valid && o_ready;
   assign any_branch = i_b || i_bc || i_bclr || i_bcctr;

   // ------------------------------------------------------------------
   // CTR decrement and condition evaluation (pre-update CTR)
   // ------------------------------------------------------------------
   logic             dec_en;
   logic [0:XLEN-1]  ctr_m;
   logic             ctr_ok;
   logic             cond_ok;

   // bcctr never decrements: it is excluded from the decrement enable,
   // which is equivalent to forcing BO[2] for it.
   assign dec_en  = (i_bc || i_bclr) && !bo[2];
   assign ctr_m   = dec_en ? (ctr_q - XLEN'(1)) : ctr_q;
   assign ctr_ok  = bo[2] || ((ctr_m != '0) ^ bo[3]);
   assign cond_ok = bo[0] || (i_cr[bi] == bo[1]);

   // ------------------------------------------------------------------
   // Candidate targets
   // ------------------------------------------------------------------
   logic [0:XLEN-1]  seq_nia;
   logic [0:XLEN-1]  li_ext;
   logic [0:XLEN-1]  bd_ext;
   logic [0:XLEN-1]  li_target;
   logic [0:XLEN-1]  bd_target;
   logic [0:XLEN-1]  lr_target;
   logic [0:XLEN-1]  ctr_target;

   assign seq_nia    = i_cia + XLEN'(4);
   assign li_ext     = {{(XLEN-26){li[0]}}, li, 2'b00};
   assign bd_ext     = {{(XLEN-16){bd[0]}}, bd, 2'b00};
   assign li_target  = aa ? li_ext : (i_cia + li_ext);
   assign bd_target  = aa ? bd_ext : (i_cia + bd_ext);
   assign lr_target  = {lr_q[0:XLEN-3], 2'b00};
   assign ctr_target = {ctr_q[0:XLEN-3], 2'b00};

   // ------------------------------------------------------------------
   // Branch resolution: taken flag and selected target per branch form
   // ------------------------------------------------------------------
   logic             taken_d;
   logic [0:XLEN-1]  target_d;
   logic [0:XLEN-1]  nia_d;

   // Pick taken/target for the decoded form; undecoded falls through.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      taken_d  = 1'b0;
      target_d = seq_nia;
      if (i_b) begin
         taken_d  = 1'b1;
         target_d = li_target;
      end else if (i_bc) begin
         taken_d  = ctr_ok && cond_ok;
         target_d = bd_target;
      end else if (i_bclr) begin
         taken_d  = ctr_ok && cond_ok;
         target_d = lr_target;
      end else if (i_bcctr) begin
         taken_d  = cond_ok;
         target_d = ctr_target;
      end
   end

   assign nia_d = taken_d ? target_d : seq_nia;

   // ------------------------------------------------------------------
   // Output slot
   // ------------------------------------------------------------------

   // Load a new result on accept; drop valid once the consumer takes it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: state registers use non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      if (i_rst) begin
         o_valid <= 1'b0;
         o_taken <= 1'b0;
         o_nia   <= '0;
      end else if (accept) begin
         o_valid <= 1'b1;
         o_taken <= taken_d;
         o_nia   <= nia_d;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // CTR / LR update
   // ------------------------------------------------------------------
   logic             ctr_spr_wr;
   logic             lr_spr_wr;
   logic             lr_link;

   assign ctr_spr_wr = i_spr_we && !i_spr_sel;
   assign lr_spr_wr  = i_spr_we &&  i_spr_sel;
   assign lr_link    = accept && any_branch && lk;

   // CTR: an explicit mtctr overrides a same-cycle branch decrement.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctr_q <= RST_CTR;
      end else if (ctr_spr_wr) begin
         ctr_q <= i_spr_wdata;
      end else if (accept && dec_en) begin
         ctr_q <= ctr_m;
      end
   end

   // LR: an explicit mtlr overrides a same-cycle link update.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lr_q <= RST_LR;
      end else if (lr_spr_wr) begin
         lr_q <= i_spr_wdata;
      end else if (lr_link) begin
         lr_q <= seq_nia;
      end
   end

   assign o_ctr = ctr_q;
   assign o_lr  = lr_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: architectural model plus
// directed vectors with hand-computed expectations.
module tb_branch_cond_unit;

   localparam int XLEN = 64;
   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_B     = 4'b1000;
   localparam logic [3:0] K_BC    = 4'b0100;
   localparam logic [3:0] K_BCLR  = 4'b0010;
   localparam logic [3:0] K_BCCTR = 4'b0001;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              ready_out;
   logic [31:0]       instr;
   logic [XLEN-1:0]   cia;
   logic              b_op, bc_op, bclr_op, bcctr_op;
   logic [31:0]       cr;
   logic              spr_we, spr_sel;
   logic [XLEN-1:0]   spr_wdata;
   logic              valid_out;
   logic              ready_in;
   logic              taken;
   logic [XLEN-1:0]   nia, ctr, lr;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   branch_cond_unit #(.XLEN(XLEN)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (valid_in),
      .o_ready     (ready_out),
      .i_instr     (instr),
      .i_cia       (cia),
      .i_b         (b_op),
      .i_bc        (bc_op),
      .i_bclr      (bclr_op),
      .i_bcctr     (bcctr_op),
      .i_cr        (cr),
      .i_spr_we    (spr_we),
      .i_spr_sel   (spr_sel),
      .i_spr_wdata (spr_wdata),
      .o_valid     (valid_out),
      .i_ready     (ready_in),
      .o_taken     (taken),
      .o_nia       (nia),
      .o_ctr       (ctr),
      .o_lr        (lr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- architectural model ----------------
   // Instruction word is held as a plain number: Power bit k is numeric
   // bit 31-k, so fields are extracted with shifts and masks.
   function automatic void resolve(
      input  logic [31:0] ins, input logic [63:0] pc, input logic [3:0] kind,
      input  logic [31:0] crv, input logic [63:0] c, input logic [63:0] l,
      output bit tk, output logic [63:0] next, output bit dec, output logic [63:0] cm);
      int unsigned bo, bi;
      longint li_off, bd_off;
      shortint s;
      bit ctr_ok, cond_ok;
      logic [63:0] tgt;
      bo = (ins >> 21) & 32'h1F;
      bi = (ins >> 16) & 32'h1F;
      li_off = longint'(ins & 32'h03FF_FFFC);
      if (ins[25]) li_off = li_off - 64'h0400_0000;
      s = shortint'(ins[15:0] & 16'hFFFC);
      bd_off = longint'(s);
      dec = (kind == K_BC || kind == K_BCLR) && ((bo & 4) == 0);
      cm  = dec ? c - 64'd1 : c;
      ctr_ok  = ((bo & 4) != 0) || ((cm != 0) != ((bo & 2) != 0));
      cond_ok = ((bo & 16) != 0) || (crv[31-bi] == ((bo & 8) != 0));
      tk  = 1'b0;
      tgt = 64'd0;
      case (kind)
         K_B:     begin tk = 1'b1;             tgt = (ins[1] ? 64'd0 : pc) + 64'(li_off); end
         K_BC:    begin tk = ctr_ok && cond_ok; tgt = (ins[1] ? 64'd0 : pc) + 64'(bd_off); end
         K_BCLR:  begin tk = ctr_ok && cond_ok; tgt = l & ~64'h3; end
         K_BCCTR: begin tk = cond_ok;           tgt = c & ~64'h3; end
         default: tk = 1'b0;
      endcase
      next = tk ? tgt : pc + 64'd4;
   endfunction

   bit          m_valid, m_taken;
   logic [63:0] m_nia, m_ctr, m_lr;

   always @(posedge clk or posedge rst) begin : model
      bit acc, tk, dec;
      logic [63:0] n, cm;
      if (rst) begin
         m_valid <= 1'b0; m_taken <= 1'b0; m_nia <= '0; m_ctr <= '0; m_lr <= '0;
      end else begin
         acc = valid_in && (!m_valid || ready_in);
         resolve(instr, cia, {b_op, bc_op, bclr_op, bcctr_op}, cr, m_ctr, m_lr, tk, n, dec, cm);
         if (acc) begin
            m_valid <= 1'b1; m_taken <= tk; m_nia <= n;
         end else if (ready_in) begin
            m_valid <= 1'b0;
         end
         if (spr_we && !spr_sel) m_ctr <= spr_wdata;
         else if (acc && dec) m_ctr <= cm;
         if (spr_we && spr_sel) m_lr <= spr_wdata;
         else if (acc && instr[0] && (b_op || bc_op || bclr_op || bcctr_op)) m_lr <= cia + 64'd4;
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("ready", ready_out, !m_valid || ready_in);
      check("valid", valid_out, m_valid);
      check("ctr",   ctr,   m_ctr);
      check("lr",    lr,    m_lr);
      if (m_valid) begin
         check("taken", taken, m_taken);
         check("nia",   nia,   m_nia);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] f_b(input int li, input bit aa, input bit lk);
      return (32'd18 << 26) | ((32'(li) & 32'h00FF_FFFF) << 2) | {30'd0, aa, lk};
   endfunction
   function automatic logic [31:0] f_bc(input logic [4:0] bo, input logic [4:0] bi, input int bd, input bit aa, input bit lk);
      return (32'd16 << 26) | (32'(bo) << 21) | (32'(bi) << 16) | ((32'(bd) & 32'h3FFF) << 2) | {30'd0, aa, lk};
   endfunction
   function automatic logic [31:0] f_xl(input logic [4:0] bo, input logic [4:0] bi, input int xo, input bit lk);
      return (32'd19 << 26) | (32'(bo) << 21) | (32'(bi) << 16) | (32'(xo) << 1) | {31'd0, lk};
   endfunction

   task automatic tick();
      @(posedge clk); #2;
   endtask
   task automatic idle();
      valid_in = 1'b0; {b_op, bc_op, bclr_op, bcctr_op} = K_NONE; spr_we = 1'b0;
   endtask
   task automatic present(input logic [3:0] kind, input logic [31:0] ins, input logic [63:0] pc);
      valid_in = 1'b1; {b_op, bc_op, bclr_op, bcctr_op} = kind; instr = ins; cia = pc;
   endtask
   task automatic issue(input logic [3:0] kind, input logic [31:0] ins, input logic [63:0] pc);
      present(kind, ins, pc); tick(); idle();
   endtask
   task automatic mtspr(input bit sel, input logic [63:0] d);
      spr_we = 1'b1; spr_sel = sel; spr_wdata = d; tick(); idle();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; ready_in = 1'b1; instr = '0; cia = '0; cr = '0;
      spr_sel = 1'b0; spr_wdata = '0;
      idle();
      tick();
      check("rst_valid", valid_out, 1'b0);
      check("rst_ready", ready_out, 1'b1);
      check("rst_nia",   nia, 64'd0);
      check("rst_taken", taken, 1'b0);
      check("rst_ctr",   ctr, 64'd0);
      check("rst_lr",    lr,  64'd0);
      rst = 1'b0;
      tick();

      // b LI=0x10 relative
      issue(K_B, f_b(32'h10, 0, 0), 64'h1000);
      check("b_valid", valid_out, 1'b1);
      check("b_taken", taken, 1'b1);
      check("b_nia",   nia, 64'h1040);
      check("b_lr",    lr,  64'd0);

      // bc decrementing, branch if CTR != 0, BD = -4
      mtspr(0, 64'd2);
      issue(K_BC, f_bc(5'b10000, 0, -4, 0, 0), 64'h2000);
      check("bc1_taken", taken, 1'b1);
      check("bc1_nia",   nia, 64'h1FF0);
      check("bc1_ctr",   ctr, 64'd1);
      issue(K_BC, f_bc(5'b10000, 0, -4, 0, 0), 64'h2004);
      check("bc2_taken", taken, 1'b0);
      check("bc2_nia",   nia, 64'h2008);
      check("bc2_ctr",   ctr, 64'd0);

      // bc on CR bit 2 only
      cr = 32'h0;
      issue(K_BC, f_bc(5'b01100, 2, 8, 0, 0), 64'h3000);
      check("bccr0_taken", taken, 1'b0);
      check("bccr0_nia",   nia, 64'h3004);
      check("bccr0_ctr",   ctr, 64'd0);
      cr = 32'h2000_0000;
      issue(K_BC, f_bc(5'b01100, 2, 8, 0, 0), 64'h3000);
      check("bccr1_taken", taken, 1'b1);
      check("bccr1_nia",   nia, 64'h3020);

      // bclrl: target from old LR, LR relinked
      mtspr(1, 64'h3003);
      issue(K_BCLR, f_xl(5'b10100, 0, 16, 1), 64'h4000);
      check("bclr_taken", taken, 1'b1);
      check("bclr_nia",   nia, 64'h3000);
      check("bclr_lr",    lr,  64'h4004);

      // CTR wraps 0 -> all-ones, branch-if-zero not taken
      issue(K_BC, f_bc(5'b10010, 0, 8, 0, 0), 64'h4100);
      check("wrap_taken", taken, 1'b0);
      check("wrap_nia",   nia, 64'h4104);
      check("wrap_ctr",   ctr, 64'hFFFF_FFFF_FFFF_FFFF);

      // bcctr: never decrements, even with BO[2]=0
      mtspr(0, 64'h7001);
      issue(K_BCCTR, f_xl(5'b10100, 0, 528, 0), 64'h7100);
      check("bcctr_nia", nia, 64'h7000);
      issue(K_BCCTR, f_xl(5'b00000, 0, 528, 0), 64'h7200);
      check("bcctr2_taken", taken, 1'b1);
      check("bcctr2_nia",   nia, 64'h7000);
      check("bcctr2_ctr",   ctr, 64'h7001);

      // accept with no decode bit: sequential, no link
      issue(K_NONE, f_b(32'h10, 0, 1), 64'h7300);
      check("none_valid", valid_out, 1'b1);
      check("none_taken", taken, 1'b0);
      check("none_nia",   nia, 64'h7304);
      check("none_lr",    lr,  64'h4004);
      tick();

      // backpressure: hold, stay stable, then drain and accept together
      ready_in = 1'b0;
      issue(K_B, f_b(1, 0, 0), 64'h5000);
      present(K_B, f_b(2, 0, 0), 64'h6000);
      for (int i = 0; i < 3; i++) begin
         check("bp_ready", ready_out, 1'b0);
         check("bp_nia",   nia, 64'h5004);
         tick();
      end
      ready_in = 1'b1;
      tick();
      idle();
      check("bp_next_nia", nia, 64'h6008);
      tick();

      // SPR write beats same-cycle branch update
      mtspr(0, 64'd5);
      spr_we = 1'b1; spr_sel = 1'b0; spr_wdata = 64'h50;
      issue(K_BC, f_bc(5'b10000, 0, 16, 0, 0), 64'h8000);
      check("col_taken", taken, 1'b1);
      check("col_nia",   nia, 64'h8040);
      check("col_ctr",   ctr, 64'h50);
      spr_we = 1'b1; spr_sel = 1'b1; spr_wdata = 64'h9999;
      issue(K_B, f_b(4, 0, 1), 64'h8100);
      check("col_lr", lr, 64'h9999);

      // async reset while a result is pending
      issue(K_B, f_b(4, 0, 0), 64'h9000);
      check("pre_rst_valid", valid_out, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", valid_out, 1'b0);
      check("mid_rst_ctr",   ctr, 64'd0);
      check("mid_rst_lr",    lr,  64'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Branch resolution stage directly downstream of the condition register unit; consumes its 32-bit CR output.
- Resolves Power ISA `b`, `bc`, `bclr` and `bcctr`.
- Owns the architected CTR and LR registers and performs CTR decrement and LR link updates.
- Delivers the next instruction address (NIA) and the taken flag to fetch through a registered valid/ready output.

Parameters:
- XLEN, 64, width of addresses, CTR and LR.
- RST_CTR, 0, reset value of CTR.
- RST_LR, 0, reset value of LR.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  a branch instruction is presented.
- o_ready  out  1  unit can accept an instruction this cycle.
- i_instr  in  [0:31]  instruction word, Power bit numbering (bit 0 = MSB).
- i_cia  in  [0:XLEN-1]  address of the instruction.
- i_b, i_bc, i_bclr, i_bcctr  in  1 each  one-hot decode of the instruction (zero or one set).
- i_cr  in  [0:31]  current condition register.
- i_spr_we  in  1  mtctr/mtlr write strobe.
- i_spr_sel  in  1  0 = CTR, 1 = LR.
- i_spr_wdata  in  [0:XLEN-1]  SPR write data.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_taken  out  1  branch taken.
- o_nia  out  [0:XLEN-1]  next instruction address.
- o_ctr  out  [0:XLEN-1]  current CTR.
- o_lr  out  [0:XLEN-1]  current LR.

Behaviour:
- Reset (async): o_valid=0, o_taken=0, o_nia=0, CTR=RST_CTR, LR=RST_LR. o_ready=1 after reset.
- Handshake:
  - o_ready = !o_valid | i_ready.
  - Accept when i_valid & o_ready; result appears registered the next cycle (latency 1).
  - On an accept, o_valid=1 next cycle. If i_ready=1 and there is no accept, o_valid=0 next cycle.
  - o_taken and o_nia hold stable while o_valid & !i_ready.
  - Full throughput: back-to-back accepts are allowed.
- Instruction fields:
  - BO = instr[6:10], BI = instr[11:15].
  - BD = instr[16:29], LI = instr[6:29].
  - AA = instr[30], LK = instr[31]. BH is ignored.
- Resolution, evaluated on the accept cycle using pre-update CTR/LR:
  - CTR decrement applies for `bc` and `bclr` when BO[2]=0: ctr_m = CTR - 1 (wraps 0 to all-ones). Otherwise ctr_m = CTR.
  - `bcctr` never decrements (BO[2] is treated as 1).
  - ctr_ok = BO[2] | ((ctr_m != 0) ^ BO[3]).
  - cond_ok = BO[0] | (i_cr[BI] == BO[1]).
  - taken = 1 for `b`; ctr_ok & cond_ok for `bc` and `bclr`; cond_ok for `bcctr`.
  - Target:
    - `b`: EXTS(LI||00), plus i_cia when AA=0.
    - `bc`: EXTS(BD||00), plus i_cia when AA=0.
    - `bclr`: LR[0:XLEN-3]||00 (old LR).
    - `bcctr`: CTR[0:XLEN-3]||00.
  - o_nia = taken ? target : i_cia + 4, modulo 2^XLEN.
- State updates on accept:
  - CTR <= ctr_m when a decrement applies.
  - LR <= i_cia + 4 when LK=1, regardless of taken. `bclr` with LK uses the old LR as target.
- SPR write port:
  - Active whenever i_spr_we=1, independent of the handshake.
  - Same-cycle collision with an accepted branch updating the same SPR: the SPR write wins. The branch still evaluates using the pre-write value.
- Accept with no decode bit set: o_valid=1, o_taken=0, o_nia = i_cia + 4, no SPR update.
- o_ctr and o_lr reflect the registers directly: the new value is visible the cycle after the update.
- Reset mid-operation discards any pending result and restores reset values immediately.

Test Plan:
- Reset, then accept `b` with LI=0x000010, AA=0, i_cia=0x1000 -> next cycle o_valid=1, o_taken=1, o_nia=0x1040, LR unchanged.
- CTR=2, `bc` BO=0b10000 (decrement, branch if CTR!=0, ignore CR), BD=-4, i_cia=0x2000 -> taken, o_nia=0x1FF0, CTR=1. Repeat -> not taken, o_nia=0x2008 (i_cia+4 of the repeat, i_cia=0x2004), CTR=0.
- `bc` BO=0b01100, BI=2, i_cr[2]=0 -> not taken, o_nia=i_cia+4, CTR unchanged. With i_cr[2]=1 -> taken.
- mtlr 0x3003, then `bclr` BO=0b10100 with LK=1, i_cia=0x4000 -> o_nia=0x3000, LR=0x4004.
- Hold i_ready=0 with o_valid=1 -> o_ready=0, outputs stable, next instruction not accepted. Release -> drains, then accepts.
- Same cycle: mtctr 0x50 and `bc` decrementing CTR=5 -> branch sees ctr_m=4, CTR=0x50 afterwards. Assert i_rst while o_valid=1 -> o_valid=0 immediately.
